// File: rtl/var_iter_counter.sv
// Variable-node iteration sequencer for an iterative decoder: steps the variable-node
// index once per clock per half-iteration and counts decode iterations up to max_iter.
module var_iter_counter #(
    parameter int log2n       = 3,
    parameter int n           = 6,
    parameter int n_minus_one = 5,
    parameter int log2i       = 4,
    parameter int max_iter    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             check_done,
    input  logic             syndrome_zero,
    input  logic             start,
    output logic [log2n-1:0] var_iter_count,
    output logic [log2i-1:0] dec_iter_count,
    output logic [2:0]       state,
    output logic             var_done,
    output logic             converged
);

    // Inputs are single-cycle pulses with no handshake: check_done is acted on only
    // while in WAIT, start only while in FINISH; everything else drops them.
    typedef enum logic [2:0] {
        wait_s   = 3'b001,
        run_s    = 3'b010,
        finish_s = 3'b100
    } state_t;

    localparam logic [log2n-1:0] one_val = log2n'(1);
    localparam logic [log2n-1:0] n_val   = log2n'(n);
    localparam logic [log2n-1:0] nm1_val = log2n'(n_minus_one);
    localparam logic [log2i-1:0] max_val = log2i'(max_iter);

    state_t           state_q, state_d;
    logic [log2n-1:0] var_q, var_d;
    logic [log2i-1:0] dec_q, dec_d;
    logic             vd_q, vd_d;
    logic             conv_q, conv_d;
    logic [log2i-1:0] dec_inc;

    assign dec_inc = dec_q + log2i'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= wait_s;
            var_q   <= one_val;
            dec_q   <= '0;
            vd_q    <= 1'b0;
            conv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            var_q   <= var_d;
            dec_q   <= dec_d;
            vd_q    <= vd_d;
            conv_q  <= conv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        var_d   = var_q;
        dec_d   = dec_q;
        vd_d    = 1'b0;
        conv_d  = conv_q;
        case (state_q)
            wait_s: begin
                if (check_done) begin
                    if (syndrome_zero) begin
                        state_d = finish_s;
                        conv_d  = 1'b1;
                    end else begin
                        state_d = run_s;
                        var_d   = one_val;
                    end
                end
            end
            run_s: begin
                if (var_q <= nm1_val) begin
                    var_d = var_q + one_val;
                end else if (var_q == n_val) begin
                    vd_d  = 1'b1;
                    var_d = one_val;
                    dec_d = dec_inc;
                    if (dec_inc == max_val) begin
                        state_d = finish_s;
                        conv_d  = 1'b0;
                    end else begin
                        state_d = wait_s;
                    end
                end else begin
                    // Corrupted index above n: restart the sweep rather than run away.
                    var_d = one_val;
                end
            end
            finish_s: begin
                if (start) begin
                    state_d = wait_s;
                    dec_d   = '0;
                    conv_d  = 1'b0;
                    var_d   = one_val;
                end
            end
            default: state_d = wait_s;
        endcase
    end

    assign state          = state_q;
    assign var_iter_count = var_q;
    assign dec_iter_count = dec_q;
    assign var_done       = vd_q;
    assign converged      = conv_q;

endmodule

// File: tb/tb_var_iter_counter.sv
// Bench for var_iter_counter (built with max_iter=3): a hand-written vector table, a
// reference model feeding an expected queue, and directed multi-cycle corner cases.
module tb_var_iter_counter;

    localparam int N    = 6;
    localparam int MAXI = 3;
    localparam int W    = 12;
    localparam logic [2:0] S_WAIT = 3'b001;
    localparam logic [2:0] S_RUN  = 3'b010;
    localparam logic [2:0] S_FIN  = 3'b100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       check_done = 1'b0;
    logic       syndrome_zero = 1'b0;
    logic       start = 1'b0;
    logic [2:0] var_iter_count;
    logic [3:0] dec_iter_count;
    logic [2:0] state;
    logic       var_done;
    logic       converged;

    var_iter_counter #(
        .log2n(3), .n(N), .n_minus_one(N - 1), .log2i(4), .max_iter(MAXI)
    ) dut (
        .clk(clk),
        .rst(rst),
        .check_done(check_done),
        .syndrome_zero(syndrome_zero),
        .start(start),
        .var_iter_count(var_iter_count),
        .dec_iter_count(dec_iter_count),
        .state(state),
        .var_done(var_done),
        .converged(converged)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         cd;
        logic         sz;
        logic         st;
        logic [W-1:0] exp;
    } vec_t;

    vec_t         vecs[19];
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           vd_seen  = 0;
    int           run_seen = 0;

    logic [2:0] m_state;
    logic [2:0] m_var;
    logic [3:0] m_dec;
    logic       m_vd;
    logic       m_conv;

    function automatic logic [W-1:0] pack(input logic [2:0] s, input logic [2:0] v,
                                          input logic [3:0] d, input logic vd,
                                          input logic cv);
        return {s, v, d, vd, cv};
    endfunction

    function automatic vec_t mk(input logic cd, input logic sz, input logic st,
                                input logic [2:0] s, input logic [2:0] v,
                                input logic [3:0] d, input logic vd, input logic cv);
        vec_t r;
        r.cd = cd; r.sz = sz; r.st = st;
        r.exp = pack(s, v, d, vd, cv);
        return r;
    endfunction

    function automatic logic [W-1:0] dut_out();
        return {state, var_iter_count, dec_iter_count, var_done, converged};
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got st=%b var=%0d dec=%0d vd=%b cv=%b, want st=%b var=%0d dec=%0d vd=%b cv=%b",
                     name, got[11:9], got[8:6], got[5:2], got[1], got[0],
                     exp[11:9], exp[8:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_WAIT; m_var = 3'd1; m_dec = 4'd0; m_vd = 1'b0; m_conv = 1'b0;
    endtask

    task automatic model_step(input logic cd, input logic sz, input logic st);
        m_vd = 1'b0;
        case (m_state)
            S_WAIT: begin
                if (cd && sz) begin
                    m_state = S_FIN; m_conv = 1'b1;
                end else if (cd) begin
                    m_state = S_RUN; m_var = 3'd1;
                end
            end
            S_RUN: begin
                if (m_var != 3'(N)) begin
                    m_var = m_var + 3'd1;
                end else begin
                    m_vd  = 1'b1;
                    m_var = 3'd1;
                    m_dec = m_dec + 4'd1;
                    if (m_dec == 4'(MAXI)) begin
                        m_state = S_FIN; m_conv = 1'b0;
                    end else begin
                        m_state = S_WAIT;
                    end
                end
            end
            S_FIN: begin
                if (st) begin
                    m_state = S_WAIT; m_dec = 4'd0; m_conv = 1'b0; m_var = 3'd1;
                end
            end
            default: m_state = S_WAIT;
        endcase
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same offset.
    task automatic tick_compare(input string name);
        logic [W-1:0] exp;
        @(posedge clk);
        #1;
        if (var_done) vd_seen++;
        if (state == S_RUN) run_seen++;
        exp = exp_q.pop_front();
        check(name, dut_out(), exp);
    endtask

    task automatic drive(input logic cd, input logic sz, input logic st);
        check_done = cd; syndrome_zero = sz; start = st;
    endtask

    task automatic step(input logic cd, input logic sz, input logic st, input string name);
        drive(cd, sz, st);
        model_step(cd, sz, st);
        exp_q.push_back(pack(m_state, m_var, m_dec, m_vd, m_conv));
        tick_compare(name);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("reset_state", dut_out(), pack(S_WAIT, 3'd1, 4'd0, 1'b0, 1'b0));
    endtask

    initial begin
        vecs[0]  = mk(1, 0, 0, S_RUN, 1, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, S_RUN, 2, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, S_RUN, 3, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, S_RUN, 4, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, S_RUN, 5, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, S_RUN, 6, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0, S_WAIT, 1, 1, 1, 0);
        vecs[7]  = mk(0, 0, 0, S_WAIT, 1, 1, 0, 0);
        vecs[8]  = mk(1, 1, 0, S_FIN, 1, 1, 0, 1);
        vecs[9]  = mk(1, 0, 0, S_FIN, 1, 1, 0, 1);
        vecs[10] = mk(0, 0, 1, S_WAIT, 1, 0, 0, 0);
        vecs[11] = mk(0, 0, 1, S_WAIT, 1, 0, 0, 0);
        vecs[12] = mk(1, 0, 1, S_RUN, 1, 0, 0, 0);
        vecs[13] = mk(0, 0, 1, S_RUN, 2, 0, 0, 0);
        vecs[14] = mk(0, 0, 0, S_RUN, 3, 0, 0, 0);
        vecs[15] = mk(0, 0, 0, S_RUN, 4, 0, 0, 0);
        vecs[16] = mk(0, 0, 0, S_RUN, 5, 0, 0, 0);
        vecs[17] = mk(0, 0, 0, S_RUN, 6, 0, 0, 0);
        vecs[18] = mk(0, 0, 0, S_WAIT, 1, 1, 1, 0);

        // Vector table: one full half-iteration, convergence, restart, ignored pulses.
        do_reset();
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].cd, vecs[i].sz, vecs[i].st);
            exp_q.push_back(vecs[i].exp);
            tick_compare($sformatf("vec%0d", i));
        end

        // Ten check_done pulses: only three half-iterations fit before forced finish.
        do_reset();
        vd_seen = 0;
        for (int p = 0; p < 10; p++) begin
            step(1'b1, 1'b0, 1'b0, "maxiter_pulse");
            repeat (3) step(1'b0, 1'b0, 1'b0, "maxiter_idle");
        end
        check_int("maxiter_vd_pulses", vd_seen, MAXI);
        check("maxiter_final", dut_out(), pack(S_FIN, 3'd1, 4'(MAXI), 1'b0, 1'b0));

        // check_done held for three cycles across RUN entry: RUN still lasts N cycles.
        step(1'b0, 1'b0, 1'b1, "restart");
        run_seen = 0;
        vd_seen  = 0;
        repeat (3) step(1'b1, 1'b0, 1'b0, "held_cd");
        repeat (8) step(1'b0, 1'b0, 1'b0, "held_idle");
        check_int("held_run_cycles", run_seen, N);
        check_int("held_vd_pulses", vd_seen, 1);

        // Asynchronous reset at var_iter_count=4 in RUN.
        step(1'b1, 1'b0, 1'b0, "rst_enter");
        repeat (3) step(1'b0, 1'b0, 1'b0, "rst_count");
        check("rst_pre", dut_out(), pack(S_RUN, 3'd4, 4'd1, 1'b0, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", dut_out(), pack(S_WAIT, 3'd1, 4'd0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        vd_seen = 0;
        repeat (8) step(1'b0, 1'b0, 1'b0, "rst_after");
        check_int("rst_no_vd", vd_seen, 0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0, "random");
        end

        check_int("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/var_iter_counter.md
VAR_ITER_COUNTER -- requirements
Module: var_iter_counter

Interface
REQ-001 SHALL have parameters, one per line:
- log2n, 3, width of the variable-node index counter.
- n, 6, number of variable-node steps per half-iteration.
- n_minus_one, 5, value n-1.
- log2i, 4, width of the decode-iteration counter.
- max_iter, 10, decode iterations before forced finish.
REQ-002 SHALL have ports, one per line:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- check_done  input  1  one-cycle pulse: check-node half-iteration complete.
- syndrome_zero  input  1  all parity checks satisfied; sampled only with check_done.
- start  input  1  pulse: begin a new codeword; honoured only in FINISH.
- var_iter_count  output  log2n  current variable-node index, 1..n.
- dec_iter_count  output  log2i  completed decode iterations.
- state  output  3  one-hot phase: 3'b001 WAIT, 3'b010 RUN, 3'b100 FINISH.
- var_done  output  1  one-cycle pulse: variable-node half-iteration complete.
- converged  output  1  finish was caused by syndrome_zero.
REQ-003 SHALL drive every output directly from a register; no combinational path from any input to any output.

Function
REQ-004 State is always exactly one-hot; any other encoding SHALL be recovered to WAIT on the next clock.
REQ-005 WAIT, check_done=1, syndrome_zero=1: next state FINISH, converged<=1, counters hold.
REQ-006 WAIT, check_done=1, syndrome_zero=0: next state RUN, var_iter_count<=1.
REQ-007 WAIT, check_done=0: all registers hold.
REQ-008 RUN, var_iter_count<n: var_iter_count increments by 1 per clock.
REQ-009 RUN, var_iter_count==n, all in one edge:
- var_done<=1 (high for exactly one cycle).
- var_iter_count<=1.
- dec_iter_count<=dec_iter_count+1.
REQ-010 At that same edge, next state SHALL be FINISH with converged<=0 if dec_iter_count+1==max_iter; otherwise WAIT.
REQ-011 RUN latency: n cycles from RUN entry to the var_done pulse.
REQ-012 check_done and syndrome_zero SHALL be ignored in RUN and FINISH.
REQ-013 FINISH holds until start=1; then next state WAIT, dec_iter_count<=0, converged<=0, var_iter_count<=1.
REQ-014 start SHALL be ignored outside FINISH.
REQ-015 var_done SHALL be 0 on every cycle not covered by REQ-009.
REQ-016 dec_iter_count SHALL never exceed max_iter; no wrap-around. Parameters require max_iter < 2^log2i and n < 2^log2n.
REQ-017 check_done arriving on the same edge as the WAIT entry (var_done edge) SHALL be ignored; it is acted on only when sampled while state is WAIT.

Reset
REQ-018 On rst=1, asynchronously and independent of clk:
- state=3'b001.
- var_iter_count=1.
- dec_iter_count=0.
- var_done=0.
- converged=0.
REQ-019 Reset mid-RUN or in FINISH SHALL abandon the operation with no var_done pulse; normal operation resumes on the first clock edge after rst deasserts.

Verification
REQ-020 Reset release, then check_done with syndrome_zero=0 -> state 010; var_iter_count 1,2,...,6; var_done high for one cycle; dec_iter_count=1; state 001.
REQ-021 check_done with syndrome_zero=1 in WAIT -> state 100 next cycle; converged=1; dec_iter_count unchanged.
REQ-022 max_iter=3, ten check_done pulses each with syndrome_zero=0 -> exactly three var_done pulses, then state 100, dec_iter_count=3, converged=0; remaining pulses ignored.
REQ-023 In FINISH, pulse start -> state 001, dec_iter_count=0, converged=0; start pulsed in WAIT or RUN -> no effect.
REQ-024 Assert rst while var_iter_count=4 in RUN -> all outputs return to reset values immediately, before the next clock edge; no var_done pulse.
REQ-025 check_done held high for 3 cycles across the RUN entry -> only the first is consumed; RUN still lasts exactly 6 cycles.
